// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for a byte-addressed 64-bit data memory.
// Port 0 is the CPU load/store unit, port 1 the program loader / debug port.
// Each access takes three cycles: IDLE (arbitrate and latch), ACC (drive the memory),
// and RSP (return the response). Ties are broken round-robin.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req*_i, we*_i, size*_i        request, store flag, size (0 byte .. 3 dword)
//   addr*_i, wdata*_i             byte address, LSB-aligned store data
//   gnt*_o                        one-cycle grant pulse (ACC cycle)
//   rvalid*_o, err*_o             one-cycle response pulse; err marks a rejected access
//   rdata_o                       registered load data, bytes above the size forced to 0
//   mem_*                         memory-side read/write interface
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [1:0]        size0_i,
  input  logic [1:0]        size1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [63:0]       wdata0_i,
  input  logic [63:0]       wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [63:0]       rdata_o,
  output logic              mem_rden_o,
  output logic [7:0]        mem_wren_o,
  output logic [ADDR_W-1:0] mem_rdaddress_o,
  output logic [ADDR_W-1:0] mem_wraddress_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i
);

  localparam logic [ADDR_W:0] LastByte = (ADDR_W+1)'(MEM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StRsp} state_e;

  state_e state_q, state_d;

  logic              last_grant_q;
  logic              port_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;

  logic              take;
  logic              sel_port;
  logic              aligned;
  logic              in_range;
  logic              access_ok;
  logic [3:0]        span_m1;
  logic [ADDR_W:0]   last_addr;
  logic [7:0]        wren_code;
  logic [63:0]       size_mask;

  // On a tie pick the port that did not win last time.
  assign take     = (state_q == StIdle) && (req0_i || req1_i);
  assign sel_port = (req0_i && req1_i) ? ~last_grant_q : req1_i;

  // Access decode from the latched request.
  always_comb begin
    span_m1   = 4'd0;
    aligned   = 1'b1;
    wren_code = 8'h01;
    size_mask = 64'h0000_0000_0000_00ff;
    unique case (size_q)
      2'd0: begin
        span_m1   = 4'd0;
        aligned   = 1'b1;
        wren_code = 8'h01;
        size_mask = 64'h0000_0000_0000_00ff;
      end
      2'd1: begin
        span_m1   = 4'd1;
        aligned   = (addr_q[0] == 1'b0);
        wren_code = 8'h03;
        size_mask = 64'h0000_0000_0000_ffff;
      end
      2'd2: begin
        span_m1   = 4'd3;
        aligned   = (addr_q[1:0] == 2'b00);
        wren_code = 8'h0f;
        size_mask = 64'h0000_0000_ffff_ffff;
      end
      default: begin
        span_m1   = 4'd7;
        aligned   = (addr_q[2:0] == 3'b000);
        wren_code = 8'hff;
        size_mask = 64'hffff_ffff_ffff_ffff;
      end
    endcase
  end

  // One extra bit so an access running past the top of the address space cannot wrap.
  assign last_addr = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, span_m1};
  assign in_range  = (last_addr <= LastByte);
  assign access_ok = aligned && in_range;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req0_i || req1_i) state_d = StAcc;
      StAcc:   state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, fairness pointer and load data capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      if (take) begin
        last_grant_q <= sel_port;
        port_q       <= sel_port;
        we_q         <= sel_port ? we1_i    : we0_i;
        size_q       <= sel_port ? size1_i  : size0_i;
        addr_q       <= sel_port ? addr1_i  : addr0_i;
        wdata_q      <= sel_port ? wdata1_i : wdata0_i;
      end
      if ((state_q == StAcc) && access_ok && !we_q) begin
        rdata_q <= mem_rdata_i & size_mask;
      end
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    gnt0_o          = 1'b0;
    gnt1_o          = 1'b0;
    rvalid0_o       = 1'b0;
    rvalid1_o       = 1'b0;
    err0_o          = 1'b0;
    err1_o          = 1'b0;
    mem_rden_o      = 1'b0;
    mem_wren_o      = 8'h00;
    mem_rdaddress_o = '0;
    mem_wraddress_o = '0;
    mem_wdata_o     = '0;
    unique case (state_q)
      StAcc: begin
        gnt0_o = ~port_q;
        gnt1_o = port_q;
        if (access_ok) begin
          if (we_q) begin
            mem_wren_o      = wren_code;
            mem_wraddress_o = addr_q;
            mem_wdata_o     = wdata_q;
          end else begin
            mem_rden_o      = 1'b1;
            mem_rdaddress_o = addr_q;
          end
        end
      end
      StRsp: begin
        rvalid0_o = ~port_q;
        rvalid1_o = port_q;
        err0_o    = ~port_q & ~access_ok;
        err1_o    = port_q & ~access_ok;
      end
      default: ;
    endcase
  end

  assign rdata_o = rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the byte-addressed 64-bit data memory (64K x 8, combinational read, posedge write with byte-lane write-enable codes).
- Port 0 is the CPU load/store unit; port 1 is the program loader/debug port.
- Serialises accesses with round-robin fairness, converts access size into the memory write-enable code, checks alignment and bounds, and returns registered read data with a response strobe.

Parameters:
- ADDR_W, 16, byte-address width driven to the memory.
- MEM_BYTES, 65536, memory size in bytes, used for the bounds check.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0/req1  in  1  access request; held until the matching gnt.
- we0/we1  in  1  1 = store, 0 = load.
- size0/size1  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- addr0/addr1  in  ADDR_W  byte address.
- wdata0/wdata1  in  64  store data, LSB-aligned.
- gnt0/gnt1  out  1  one-cycle grant pulse.
- rvalid0/rvalid1  out  1  one-cycle response pulse; for stores, it signals write completion.
- err0/err1  out  1  valid with rvalid; the access was rejected.
- rdata  out  64  load data, valid with rvalid; raw bytes, requester extends.
- mem_rden  out  1  to memory rden.
- mem_wren  out  8  to memory wren.
- mem_rdaddress  out  ADDR_W  to memory rdaddress.
- mem_wraddress  out  ADDR_W  to memory wraddress.
- mem_wdata  out  64  to memory write_data.
- mem_rdata  in  64  from memory read_data.

Behaviour:
- Reset values: state IDLE; last_grant = 1, so port 0 wins the first tie. All gnt, rvalid and err are 0; rdata = 0; mem_rden = 0; mem_wren = 8'h00; addresses and mem_wdata = 0.
- Reset mid-access: outputs clear immediately (asynchronous). mem_wren drops before the next edge, so no write commits. An in-flight transaction is dropped and no response is issued.
- FSM IDLE:
  - Sample req0/req1.
  - One request: select that port.
  - Both requesting: select the port != last_grant.
  - On the edge, latch port id, we, size, addr and wdata; update last_grant; go to ACC.
  - No request: stay in IDLE.
- FSM ACC (1 cycle):
  - gnt<port> = 1.
  - Validity check: addr[size-1:0] must be 0 (alignment), and addr + 2^size - 1 must be <= MEM_BYTES - 1, evaluated at ADDR_W+1 bits so there is no wrap-around.
  - Valid store: mem_wraddress = addr; mem_wdata = wdata; mem_wren = 01 / 03 / 0F / FF for size 0 / 1 / 2 / 3. The write commits at the edge ending ACC.
  - Valid load: mem_rden = 1; mem_rdaddress = addr. At the edge, capture rdata = mem_rdata with bytes above the access size forced to 0.
  - Invalid access: mem_rden = 0, mem_wren = 0.
  - Go to RSP.
- FSM RSP (1 cycle):
  - rvalid<port> = 1.
  - err<port> = 1 if invalid.
  - rdata is held until the next load capture; stores and errors leave it unchanged.
  - Go to IDLE.
- Timing: gnt occurs one cycle after req is seen in IDLE; rvalid occurs two cycles after req. Throughput is one access per 3 cycles.
- Requester rule: deassert or change req at the edge ending the gnt cycle. req is ignored outside IDLE.
- Memory-side rule: mem_wren is 00 and mem_rden is 0 in every state except a valid ACC. Both are never active together.
- Starvation bound: with continuous requests on both ports, grants strictly alternate.

Test Plan:
- Port 0 store dword: addr = 0x0010, wdata = 0x1122334455667788, then port 0 load dword at 0x0010 -> mem_wren = FF for one cycle; load rvalid0 with rdata = 0x1122334455667788, err0 = 0.
- Store half at 0x0020, data = 0xAAAA_BBBB_CCCC_DDDD, then load dword at 0x0020 -> mem_wren = 03; rdata = 0x000000000000DDDD (only bytes 0x20-0x21 written, over prior zeroed memory).
- req0 and req1 asserted together and held continuously for 4 transactions -> grants go 0, 1, 0, 1. gnt pulses are spaced 3 cycles apart, and each rvalid follows its gnt by exactly 1 cycle.
- Misaligned and out-of-range accesses: word store at 0x0006, dword load at 0xFFFC, byte store at 0xFFFF -> first two return err = 1 with mem_wren = 0 and mem_rden = 0 throughout; third succeeds, err = 0, mem_wren = 01.
- rst asserted during the ACC cycle of a dword store to 0x0040 -> mem_wren = 00 immediately; memory at 0x0040 is unchanged; no rvalid. After release, a port 0 request wins over a simultaneous port 1 request.
- Idle bus: no requests for 10 cycles -> mem_wren = 00, mem_rden = 0, and all gnt, rvalid and err outputs stay 0.
